// File: rtl/slip_frame_decoder.sv
// slip_frame_decoder: SLIP (RFC 1055) de-framer between a UART byte stream and
// the packet layer. One decoded byte is held back so that END can tag it as the
// last byte of its frame. Errors abort the frame and pulse protocol_error.
// Optional feature macro: SLIP_FRAME_DECODER_FRAME_COUNT_EN adds frame_count[15:0],
// a count of frames delivered without abort.
module slip_frame_decoder #(
  parameter int MAX_FRAME_LENGTH = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        out_abort,
`ifdef SLIP_FRAME_DECODER_FRAME_COUNT_EN
  output logic [15:0] frame_count,
`endif
  output logic        protocol_error
);

  localparam int         LEN_W   = $clog2(MAX_FRAME_LENGTH + 1);
  localparam logic [7:0] C_END   = 8'hC0;
  localparam logic [7:0] C_ESC   = 8'hDB;
  localparam logic [7:0] C_E_END = 8'hDC;
  localparam logic [7:0] C_E_ESC = 8'hDD;

  typedef enum logic [1:0] {HUNT, DATA, ESCAPE} state_t;

  state_t             state_q, state_d;
  logic               hold_valid_q;
  logic [7:0]         hold_data_q;
  logic [LEN_W-1:0]   len_q;
  logic               out_valid_q, out_last_q, out_abort_q, perr_q;
  logic [7:0]         out_data_q;

  logic               acc;
  logic               dec_v;       // a decoded byte is to be stored this cycle
  logic [7:0]         dec_b;
  logic               frame_end;   // END closing a frame in DATA
  logic               err_abort;   // frame aborted by bad escape / over-length

  // A new byte may enter only when the output slot is free or draining now,
  // so any emit triggered by that byte always has room.
  assign in_ready = !out_valid_q || out_ready;
  assign acc      = in_valid && in_ready;

  // Classify the accepted byte and pick the next FSM state.
  always_comb begin
    state_d   = state_q;
    dec_v     = 1'b0;
    dec_b     = in_data;
    frame_end = 1'b0;
    err_abort = 1'b0;
    if (acc) begin
      case (state_q)
        HUNT: if (in_data == C_END) state_d = DATA;
        DATA: begin
          if (in_data == C_END)      frame_end = 1'b1;
          else if (in_data == C_ESC) state_d = ESCAPE;
          else                       dec_v = 1'b1;
        end
        ESCAPE: begin
          if (in_data == C_E_END) begin
            dec_v = 1'b1; dec_b = C_END; state_d = DATA;
          end else if (in_data == C_E_ESC) begin
            dec_v = 1'b1; dec_b = C_ESC; state_d = DATA;
          end else if (in_data == C_END) begin
            // END still delimits, so the next frame starts immediately
            err_abort = 1'b1; state_d = DATA;
          end else begin
            err_abort = 1'b1; state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
      // A full frame cannot take another byte: drop it and abort.
      if (dec_v && len_q == LEN_W'(MAX_FRAME_LENGTH)) begin
        dec_v     = 1'b0;
        err_abort = 1'b1;
        state_d   = HUNT;
      end
    end
  end

  // FSM, holding register, length counter and registered output slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= HUNT;
      hold_valid_q <= 1'b0;
      hold_data_q  <= 8'h00;
      len_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      out_last_q   <= 1'b0;
      out_abort_q  <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      perr_q  <= err_abort;
      if (in_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        out_abort_q <= 1'b0;
      end
      if (frame_end || err_abort) begin
        if (hold_valid_q) begin
          out_valid_q <= 1'b1;
          out_data_q  <= hold_data_q;
          out_last_q  <= 1'b1;
          out_abort_q <= err_abort;
        end
        hold_valid_q <= 1'b0;
        len_q        <= '0;
      end else if (dec_v) begin
        if (hold_valid_q) begin
          out_valid_q <= 1'b1;
          out_data_q  <= hold_data_q;
        end
        hold_data_q  <= dec_b;
        hold_valid_q <= 1'b1;
        len_q        <= len_q + LEN_W'(1);
      end
    end
  end

`ifdef SLIP_FRAME_DECODER_FRAME_COUNT_EN
  logic [15:0] frame_count_q;
  // Count good frames as their last byte leaves; wraps naturally.
  always_ff @(posedge clock) begin
    if (reset)
      frame_count_q <= 16'h0000;
    else if (out_valid_q && out_ready && out_last_q && !out_abort_q)
      frame_count_q <= frame_count_q + 16'h0001;
  end
  assign frame_count = frame_count_q;
`endif

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_last       = out_last_q;
  assign out_abort      = out_abort_q;
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_slip_frame_decoder.sv
// Directed bench for slip_frame_decoder: a default-size instance and a
// MAX_FRAME_LENGTH=4 instance share the input data and output ready.
module tb_slip_frame_decoder;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0, in_valid2 = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, out_last, out_abort, protocol_error;
  logic [7:0] out_data;
  logic       in_ready2, out_valid2, out_last2, out_abort2, protocol_error2;
  logic [7:0] out_data2;
`ifdef SLIP_FRAME_DECODER_FRAME_COUNT_EN
  logic [15:0] frame_count, frame_count2;
`endif

  int checks = 0;
  int errors = 0;
  int ec1 = 0, ec2 = 0;
  logic [9:0] q1[$];
  logic [9:0] q2[$];

  slip_frame_decoder u_dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_abort(out_abort),
`ifdef SLIP_FRAME_DECODER_FRAME_COUNT_EN
    .frame_count(frame_count),
`endif
    .protocol_error(protocol_error)
  );

  slip_frame_decoder #(.MAX_FRAME_LENGTH(4)) u_dut4 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_last(out_last2), .out_abort(out_abort2),
`ifdef SLIP_FRAME_DECODER_FRAME_COUNT_EN
    .frame_count(frame_count2),
`endif
    .protocol_error(protocol_error2)
  );

  always #5 clock = ~clock;

  // Record output handshakes and error pulses away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid && out_ready)   q1.push_back({out_data, out_last, out_abort});
      if (out_valid2 && out_ready)  q2.push_back({out_data2, out_last2, out_abort2});
      if (protocol_error)  ec1++;
      if (protocol_error2) ec2++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends one byte to dut (sel=0) or dut4 (sel=1); starts and ends at posedge+1.
  task automatic send(input int sel, input logic [7:0] b);
    int t = 0;
    in_data = b;
    if (sel == 0) in_valid = 1'b1; else in_valid2 = 1'b1;
    @(negedge clock);
    while (((sel == 0) ? in_ready : in_ready2) !== 1'b1 && t < 50) begin
      @(negedge clock); t++;
    end
    chk("send_ready", {31'd0, (sel == 0) ? in_ready : in_ready2}, 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0; in_valid2 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pop(input int sel, input string tag, input logic [7:0] d, input logic l, input logic a);
    logic [9:0] v;
    v = 'x;
    if (sel == 0) begin if (q1.size() > 0) v = q1.pop_front(); end
    else          begin if (q2.size() > 0) v = q2.pop_front(); end
    chk(tag, {22'd0, v}, {22'd0, d, l, a});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1;
    idle(2);
    reset = 1'b0;
    q1.delete(); q2.delete();
    ec1 = 0; ec2 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    // reset state
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last",  {31'd0, out_last},  32'd0);
    chk("rst_out_abort", {31'd0, out_abort}, 32'd0);
    chk("rst_out_data",  {24'd0, out_data},  32'd0);
    chk("rst_perr",      {31'd0, protocol_error}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);

    // 1: plain frame
    send(0, 8'hC0); send(0, 8'h41);
    chk("t1_latency", {31'd0, out_valid}, 32'd0);
    send(0, 8'h42); send(0, 8'hC0); idle(3);
    pop(0, "t1_b0", 8'h41, 1'b0, 1'b0);
    pop(0, "t1_b1", 8'h42, 1'b1, 1'b0);
    chk("t1_left", q1.size(), 0);
    chk("t1_err", ec1, 0);
`ifdef SLIP_FRAME_DECODER_FRAME_COUNT_EN
    chk("t1_fcount", {16'd0, frame_count}, 32'd1);
`endif

    // 2: escapes
    send(0, 8'hC0); send(0, 8'hDB); send(0, 8'hDC);
    send(0, 8'hDB); send(0, 8'hDD); send(0, 8'hC0); idle(3);
    pop(0, "t2_b0", 8'hC0, 1'b0, 1'b0);
    pop(0, "t2_b1", 8'hDB, 1'b1, 1'b0);
    chk("t2_left", q1.size(), 0);
    chk("t2_err", ec1, 0);
`ifdef SLIP_FRAME_DECODER_FRAME_COUNT_EN
    chk("t2_fcount", {16'd0, frame_count}, 32'd2);
`endif

    // 3: hunt from reset, then empty frames
    do_reset();
    send(0, 8'h11); send(0, 8'hC0); send(0, 8'h22); send(0, 8'hC0);
    send(0, 8'hC0); send(0, 8'hC0); idle(3);
    pop(0, "t3_b0", 8'h22, 1'b1, 1'b0);
    chk("t3_left", q1.size(), 0);
    chk("t3_err", ec1, 0);

    // 4: bad escape -> abort + hunt, then recovery
    send(0, 8'hC0); send(0, 8'h33); send(0, 8'hDB); send(0, 8'h44);
    send(0, 8'h55); send(0, 8'hC0); send(0, 8'h66); send(0, 8'hC0); idle(3);
    pop(0, "t4_abort", 8'h33, 1'b1, 1'b1);
    pop(0, "t4_next",  8'h66, 1'b1, 1'b0);
    chk("t4_left", q1.size(), 0);
    chk("t4_err", ec1, 1);

    // 4b: ESC followed by END aborts but END still opens a new frame
    ec1 = 0;
    send(0, 8'h77); send(0, 8'hDB); send(0, 8'hC0);
    send(0, 8'h88); send(0, 8'hC0); idle(3);
    pop(0, "t4b_abort", 8'h77, 1'b1, 1'b1);
    pop(0, "t4b_next",  8'h88, 1'b1, 1'b0);
    chk("t4b_left", q1.size(), 0);
    chk("t4b_err", ec1, 1);

    // 5: over-length on MAX_FRAME_LENGTH=4
    send(1, 8'hC0); send(1, 8'h01); send(1, 8'h02); send(1, 8'h03);
    send(1, 8'h04); send(1, 8'h05); send(1, 8'hC0); idle(3);
    pop(1, "t5_b0", 8'h01, 1'b0, 1'b0);
    pop(1, "t5_b1", 8'h02, 1'b0, 1'b0);
    pop(1, "t5_b2", 8'h03, 1'b0, 1'b0);
    pop(1, "t5_b3", 8'h04, 1'b1, 1'b1);
    chk("t5_left", q2.size(), 0);
    chk("t5_err", ec2, 1);
    // exactly MAX bytes is a legal frame
    send(1, 8'h0A); send(1, 8'h0B); send(1, 8'h0C); send(1, 8'h0D);
    send(1, 8'hC0); idle(3);
    pop(1, "t5m_b0", 8'h0A, 1'b0, 1'b0);
    pop(1, "t5m_b1", 8'h0B, 1'b0, 1'b0);
    pop(1, "t5m_b2", 8'h0C, 1'b0, 1'b0);
    pop(1, "t5m_b3", 8'h0D, 1'b1, 1'b0);
    chk("t5m_left", q2.size(), 0);
    chk("t5m_err", ec2, 1);

    // 6: backpressure mid-frame
    out_ready = 1'b0;
    send(0, 8'hC0); send(0, 8'hA1); send(0, 8'hA2);
    in_data = 8'hA3; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("t6_in_ready",  {31'd0, in_ready},  32'd0);
      chk("t6_out_valid", {31'd0, out_valid}, 32'd1);
      chk("t6_out_data",  {24'd0, out_data},  32'hA1);
      chk("t6_out_last",  {31'd0, out_last},  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    send(0, 8'hC0); idle(3);
    pop(0, "t6_b0", 8'hA1, 1'b0, 1'b0);
    pop(0, "t6_b1", 8'hA2, 1'b0, 1'b0);
    pop(0, "t6_b2", 8'hA3, 1'b1, 1'b0);
    chk("t6_left", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
